wb_commit_queue: RTL and testbench
==================================

Name: wb_commit_queue

Overview:
- Writeback-side producer for the dual-write-port register file.
- Accepts up to two in-order results per cycle from the execute stage into a small circular queue.
- Drains up to two entries per cycle onto the register-file write ports. Older entry goes on port 1, younger on port 2, which matches port-2 priority on same-address writes.
- Sits between the execute/writeback pipeline and the register file.

Parameters:
- DEPTH, 8, queue entries; power of two, >= 4.
- PTR_W, 3, pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- flush_i  in  1  discard all queued and outgoing writes
- stall_i  in  1  hold draining; enqueue still allowed
- in0_valid_i  in  1  result 0 valid (older)
- in0_addr_i  in  5  result 0 destination
- in0_data_i  in  32  result 0 value
- in0_ready_o  out  1  result 0 accepted this cycle if valid
- in1_valid_i  in  1  result 1 valid (younger)
- in1_addr_i  in  5  result 1 destination
- in1_data_i  in  32  result 1 value
- in1_ready_o  out  1  result 1 accepted this cycle if valid
- we1_o  out  1  regfile write enable, port 1
- waddr1_o  out  5  regfile write address, port 1
- wdata1_o  out  32  regfile write data, port 1
- we2_o  out  1  regfile write enable, port 2
- waddr2_o  out  5  regfile write address, port 2
- wdata2_o  out  32  regfile write data, port 2
- count_o  out  PTR_W+1  entries currently queued

Behaviour:
- Reset (async, rst=1):
  - head, tail and count are 0.
  - we1_o and we2_o are 0; waddr*/wdata* are 0; count_o is 0.
  - Queue storage contents are don't-care.
- Ready:
  - Computed from the registered count only, independent of the valid inputs and of same-cycle pops.
  - in0_ready_o = (DEPTH - count >= 1).
  - in1_ready_o = (DEPTH - count >= 2).
  - Both ready outputs are 0 while flush_i=1.
- Enqueue, on the clock edge:
  - Each accepted result with addr != 0 is written at tail, in0 first, then in1.
  - tail advances by the number written, modulo DEPTH.
  - Results with addr == 0 are accepted (ready honoured) but not stored.
  - in1 valid with in0 invalid enqueues in1 alone.
- Drain:
  - When stall_i=0, the oldest min(count, 2) entries are popped.
  - The oldest popped entry loads port 1 registers (we1_o=1).
  - The second popped entry loads port 2 registers (we2_o=1).
  - With one entry popped, that entry goes on port 1 and we2_o=0.
  - With nothing popped, or stall_i=1, both we*_o are 0 next cycle; address/data registers hold.
  - Drain sees only entries present at the start of the cycle.
- Latency: a result accepted in cycle N is queued at edge N. At the earliest it is popped in cycle N+1, so it drives the write ports during cycle N+2.
- Count update: count_next = count + enq - pop, range 0..DEPTH. Simultaneous enqueue and pop at full is legal because ready is conservative.
- Wrap-around: head and tail wrap modulo DEPTH. Port 1/port 2 ordering stays oldest-first across the wrap.
- Same-address writes:
  - Never merged or reordered.
  - Two same-address entries popped together go oldest on port 1 and youngest on port 2, so the regfile keeps the youngest.
- flush_i=1:
  - At the edge, head = tail = count = 0 and we1_o = we2_o = 0.
  - Inputs presented that cycle are not accepted.
  - flush_i has priority over stall_i and enqueue.
- Reset asserted mid-operation clears everything immediately, regardless of clock.

Optional Feature:
- Macro: WB_FORWARD_EN.
- When defined, two ports are added:
  - fwd_raddr_i  in  5
  - fwd_hit_o  out  1 and fwd_data_o  out  32
- Forwarding lookup is combinational. It searches the port 2 register, then port 1, then queue entries from youngest to oldest, for the youngest pending write to fwd_raddr_i.
- On a match, fwd_hit_o=1 and fwd_data_o is that value.
- fwd_raddr_i==0 gives fwd_hit_o=0 and fwd_data_o=0.
- When not defined, the ports and search logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then in0 = (addr 3, 0x11111111) in cycle 1 -> cycle 3: we1_o=1, waddr1_o=3, wdata1_o=0x11111111, we2_o=0; count_o returns to 0.
- Same cycle in0 = (5, 0xA), in1 = (5, 0xB) -> both pop together: waddr1_o=5/wdata1_o=0xA on port 1, waddr2_o=5/wdata2_o=0xB on port 2.
- stall_i=1 while 8 results enqueue -> count_o=8, in0_ready_o=0, in1_ready_o=0. With count_o=7, in0_ready_o=1 and in1_ready_o=0. Release the stall -> 4 consecutive cycles of dual writes in enqueue order.
- in0 addr=0 with in1 = (7, 0x77) -> only addr 7 is written, on port 1; count_o never exceeds 1.
- Fill to 6 entries, pop, refill across the wrap point -> write order matches enqueue order exactly.
- flush_i with count_o=5 and a write pending on the ports -> next cycle count_o=0, we1_o=we2_o=0. With WB_FORWARD_EN, queue (9, 0x1) then (9, 0x2) -> fwd_raddr_i=9 gives fwd_hit_o=1, fwd_data_o=0x2.

Source files
------------

// File: rtl/wb_commit_queue.sv
// wb_commit_queue: writeback commit queue feeding a dual-write-port register file.
// Accepts up to two in-order results per cycle, drains up to two per cycle,
// oldest on port 1 and youngest on port 2.
// Optional forwarding lookup is compiled in with `define WB_FORWARD_EN.
module wb_commit_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             stall_i,
    input  logic             in0_valid_i,
    input  logic [4:0]       in0_addr_i,
    input  logic [31:0]      in0_data_i,
    output logic             in0_ready_o,
    input  logic             in1_valid_i,
    input  logic [4:0]       in1_addr_i,
    input  logic [31:0]      in1_data_i,
    output logic             in1_ready_o,
    output logic             we1_o,
    output logic [4:0]       waddr1_o,
    output logic [31:0]      wdata1_o,
    output logic             we2_o,
    output logic [4:0]       waddr2_o,
    output logic [31:0]      wdata2_o,
    output logic [PTR_W:0]   count_o
`ifdef WB_FORWARD_EN
    ,
    input  logic [4:0]       fwd_raddr_i,
    output logic             fwd_hit_o,
    output logic [31:0]      fwd_data_o
`endif
);

    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             we1_q, we1_d, we2_q, we2_d;
    logic [4:0]       waddr1_q, waddr1_d, waddr2_q, waddr2_d;
    logic [31:0]      wdata1_q, wdata1_d, wdata2_q, wdata2_d;
    logic [4:0]       mem_addr_q [DEPTH];
    logic [31:0]      mem_data_q [DEPTH];

    logic             wr0, wr1;
    logic [1:0]       enq_n, pop_n;
    logic [PTR_W-1:0] tail_plus, head_plus1;

    // Ready depends only on registered occupancy; blocked entirely during flush
    always_comb begin
        in0_ready_o = !flush_i && (count_q < CNT_W'(DEPTH));
        in1_ready_o = !flush_i && (count_q < CNT_W'(DEPTH - 1));
    end

    // Accepted results with a nonzero destination are stored; pop count from start-of-cycle occupancy
    always_comb begin
        wr0        = in0_valid_i && in0_ready_o && (in0_addr_i != 5'd0);
        wr1        = in1_valid_i && in1_ready_o && (in1_addr_i != 5'd0);
        enq_n      = {1'b0, wr0} + {1'b0, wr1};
        tail_plus  = tail_q + PTR_W'(wr0);
        head_plus1 = head_q + PTR_W'(1);
        pop_n      = 2'd0;
        if (!stall_i) begin
            pop_n = (count_q >= CNT_W'(2)) ? 2'd2 : count_q[1:0];
        end
    end

    // Next-state for pointers, count and write-port registers; flush wins over everything
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        we1_d    = 1'b0;
        we2_d    = 1'b0;
        waddr1_d = waddr1_q;
        wdata1_d = wdata1_q;
        waddr2_d = waddr2_q;
        wdata2_d = wdata2_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(pop_n);
            tail_d  = tail_q + PTR_W'(enq_n);
            count_d = count_q + CNT_W'(enq_n) - CNT_W'(pop_n);
            if (pop_n != 2'd0) begin
                we1_d    = 1'b1;
                waddr1_d = mem_addr_q[head_q];
                wdata1_d = mem_data_q[head_q];
            end
            if (pop_n == 2'd2) begin
                we2_d    = 1'b1;
                waddr2_d = mem_addr_q[head_plus1];
                wdata2_d = mem_data_q[head_plus1];
            end
        end
    end

    // Control and write-port registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            we1_q    <= 1'b0;
            we2_q    <= 1'b0;
            waddr1_q <= '0;
            wdata1_q <= '0;
            waddr2_q <= '0;
            wdata2_q <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            we1_q    <= we1_d;
            we2_q    <= we2_d;
            waddr1_q <= waddr1_d;
            wdata1_q <= wdata1_d;
            waddr2_q <= waddr2_d;
            wdata2_q <= wdata2_d;
        end
    end

    // Queue storage: in0 at tail, in1 right after it (or at tail when in0 is not stored)
    always_ff @(posedge clk) begin
        if (wr0) begin
            mem_addr_q[tail_q] <= in0_addr_i;
            mem_data_q[tail_q] <= in0_data_i;
        end
        if (wr1) begin
            mem_addr_q[tail_plus] <= in1_addr_i;
            mem_data_q[tail_plus] <= in1_data_i;
        end
    end

    assign we1_o    = we1_q;
    assign waddr1_o = waddr1_q;
    assign wdata1_o = wdata1_q;
    assign we2_o    = we2_q;
    assign waddr2_o = waddr2_q;
    assign wdata2_o = wdata2_q;
    assign count_o  = count_q;

`ifdef WB_FORWARD_EN
    logic [PTR_W-1:0] fwd_idx;

    // Youngest pending write wins: port 1, then port 2, then queue oldest to youngest, later overrides
    always_comb begin
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        fwd_idx    = head_q;
        if (fwd_raddr_i != 5'd0) begin
            if (we1_q && (waddr1_q == fwd_raddr_i)) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = wdata1_q;
            end
            if (we2_q && (waddr2_q == fwd_raddr_i)) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = wdata2_q;
            end
            for (int i = 0; i < int'(DEPTH); i++) begin
                fwd_idx = head_q + PTR_W'(i);
                if ((CNT_W'(i) < count_q) && (mem_addr_q[fwd_idx] == fwd_raddr_i)) begin
                    fwd_hit_o  = 1'b1;
                    fwd_data_o = mem_data_q[fwd_idx];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_commit_queue.sv
// Directed self-checking bench for wb_commit_queue (default build).
module tb_wb_commit_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i, stall_i;
    logic        in0_valid_i, in1_valid_i;
    logic [4:0]  in0_addr_i, in1_addr_i;
    logic [31:0] in0_data_i, in1_data_i;
    logic        in0_ready_o, in1_ready_o;
    logic        we1_o, we2_o;
    logic [4:0]  waddr1_o, waddr2_o;
    logic [31:0] wdata1_o, wdata2_o;
    logic [3:0]  count_o;

    int errors = 0;
    int checks = 0;

    wb_commit_queue #(.DEPTH(8), .PTR_W(3)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .stall_i(stall_i),
        .in0_valid_i(in0_valid_i), .in0_addr_i(in0_addr_i), .in0_data_i(in0_data_i),
        .in0_ready_o(in0_ready_o),
        .in1_valid_i(in1_valid_i), .in1_addr_i(in1_addr_i), .in1_data_i(in1_data_i),
        .in1_ready_o(in1_ready_o),
        .we1_o(we1_o), .waddr1_o(waddr1_o), .wdata1_o(wdata1_o),
        .we2_o(we2_o), .waddr2_o(waddr2_o), .wdata2_o(wdata2_o),
        .count_o(count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        in0_valid_i = v0; in0_addr_i = a0; in0_data_i = d0;
        in1_valid_i = v1; in1_addr_i = a1; in1_data_i = d1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic check_pair(input string tag, input logic [4:0] a1, input logic [31:0] d1,
                              input logic [4:0] a2, input logic [31:0] d2);
        check({tag, ".we1"}, 64'(we1_o), 64'd1);
        check({tag, ".waddr1"}, 64'(waddr1_o), 64'(a1));
        check({tag, ".wdata1"}, 64'(wdata1_o), 64'(d1));
        check({tag, ".we2"}, 64'(we2_o), 64'd1);
        check({tag, ".waddr2"}, 64'(waddr2_o), 64'(a2));
        check({tag, ".wdata2"}, 64'(wdata2_o), 64'(d2));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  wa [8];
        logic [31:0] wd [8];
        rst = 1'b1; flush_i = 1'b0; stall_i = 1'b0;
        idle();
        #12;
        check("rst.count", 64'(count_o), 64'd0);
        check("rst.we1", 64'(we1_o), 64'd0);
        check("rst.we2", 64'(we2_o), 64'd0);
        check("rst.waddr1", 64'(waddr1_o), 64'd0);
        check("rst.wdata2", 64'(wdata2_o), 64'd0);
        check("rst.rdy0", 64'(in0_ready_o), 64'd1);
        check("rst.rdy1", 64'(in1_ready_o), 64'd1);
        tick();
        rst = 1'b0;

        // Single result: accepted at edge N, on port 1 after edge N+1
        drive(1'b1, 5'd3, 32'h11111111, 1'b0, 5'd0, 32'd0);
        tick();
        idle();
        check("t1.count_q", 64'(count_o), 64'd1);
        check("t1.we1_early", 64'(we1_o), 64'd0);
        tick();
        check("t1.we1", 64'(we1_o), 64'd1);
        check("t1.waddr1", 64'(waddr1_o), 64'd3);
        check("t1.wdata1", 64'(wdata1_o), 64'h11111111);
        check("t1.we2", 64'(we2_o), 64'd0);
        check("t1.count", 64'(count_o), 64'd0);
        tick();
        check("t1.we1_off", 64'(we1_o), 64'd0);

        // Same-address pair: oldest on port 1, youngest on port 2
        drive(1'b1, 5'd5, 32'hA, 1'b1, 5'd5, 32'hB);
        tick();
        idle();
        check("t2.count", 64'(count_o), 64'd2);
        tick();
        check_pair("t2", 5'd5, 32'hA, 5'd5, 32'hB);
        check("t2.count0", 64'(count_o), 64'd0);
        tick();

        // Stalled fill to full, then drain in enqueue order
        for (int i = 0; i < 8; i++) begin
            wa[i] = 5'(i + 1);
            wd[i] = 32'hA0 + 32'(i);
        end
        stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, wa[2*k], wd[2*k], 1'b1, wa[2*k+1], wd[2*k+1]);
            tick();
        end
        check("t3.count6", 64'(count_o), 64'd6);
        check("t3.we1_stall", 64'(we1_o), 64'd0);
        drive(1'b1, wa[6], wd[6], 1'b0, 5'd0, 32'd0);
        tick();
        check("t3.count7", 64'(count_o), 64'd7);
        check("t3.rdy0_7", 64'(in0_ready_o), 64'd1);
        check("t3.rdy1_7", 64'(in1_ready_o), 64'd0);
        drive(1'b1, wa[7], wd[7], 1'b0, 5'd0, 32'd0);
        tick();
        check("t3.count8", 64'(count_o), 64'd8);
        check("t3.rdy0_8", 64'(in0_ready_o), 64'd0);
        check("t3.rdy1_8", 64'(in1_ready_o), 64'd0);
        drive(1'b1, 5'd20, 32'hDEAD, 1'b1, 5'd21, 32'hBEEF);
        tick();
        check("t3.full_hold", 64'(count_o), 64'd8);
        idle();
        stall_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_pair($sformatf("t3.drain%0d", k), wa[2*k], wd[2*k], wa[2*k+1], wd[2*k+1]);
        end
        check("t3.count_end", 64'(count_o), 64'd0);
        tick();
        check("t3.we1_end", 64'(we1_o), 64'd0);
        check("t3.we2_end", 64'(we2_o), 64'd0);

        // addr 0 accepted but not stored
        drive(1'b1, 5'd0, 32'h55, 1'b1, 5'd7, 32'h77);
        tick();
        idle();
        check("t4.count", 64'(count_o), 64'd1);
        tick();
        check("t4.we1", 64'(we1_o), 64'd1);
        check("t4.waddr1", 64'(waddr1_o), 64'd7);
        check("t4.wdata1", 64'(wdata1_o), 64'h77);
        check("t4.we2", 64'(we2_o), 64'd0);
        check("t4.count0", 64'(count_o), 64'd0);
        tick();

        // Fill 6 across the wrap point, drain while refilling
        for (int i = 0; i < 8; i++) begin
            wa[i] = 5'(10 + i);
            wd[i] = 32'hC0 + 32'(i);
        end
        stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, wa[2*k], wd[2*k], 1'b1, wa[2*k+1], wd[2*k+1]);
            tick();
        end
        check("t5.count6", 64'(count_o), 64'd6);
        idle();
        stall_i = 1'b0;
        tick();
        check_pair("t5.p0", wa[0], wd[0], wa[1], wd[1]);
        check("t5.count4a", 64'(count_o), 64'd4);
        drive(1'b1, wa[6], wd[6], 1'b1, wa[7], wd[7]);
        tick();
        idle();
        check_pair("t5.p1", wa[2], wd[2], wa[3], wd[3]);
        check("t5.count4b", 64'(count_o), 64'd4);
        tick();
        check_pair("t5.p2", wa[4], wd[4], wa[5], wd[5]);
        check("t5.count2", 64'(count_o), 64'd2);
        tick();
        check_pair("t5.p3", wa[6], wd[6], wa[7], wd[7]);
        check("t5.count0", 64'(count_o), 64'd0);
        tick();

        // Flush with 5 queued and writes pending on both ports
        stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 5'(20 + 2*k), 32'(k), 1'b1, 5'(21 + 2*k), 32'(k + 16));
            tick();
        end
        drive(1'b1, 5'd26, 32'h26, 1'b0, 5'd0, 32'd0);
        tick();
        idle();
        stall_i = 1'b0;
        tick();
        check("t6.count5", 64'(count_o), 64'd5);
        check("t6.we1_pend", 64'(we1_o), 64'd1);
        check("t6.waddr1_pend", 64'(waddr1_o), 64'd20);
        flush_i = 1'b1;
        stall_i = 1'b1;
        drive(1'b1, 5'd27, 32'h27, 1'b1, 5'd28, 32'h28);
        #1;
        check("t6.rdy0_flush", 64'(in0_ready_o), 64'd0);
        check("t6.rdy1_flush", 64'(in1_ready_o), 64'd0);
        tick();
        flush_i = 1'b0;
        stall_i = 1'b0;
        idle();
        check("t6.count", 64'(count_o), 64'd0);
        check("t6.we1", 64'(we1_o), 64'd0);
        check("t6.we2", 64'(we2_o), 64'd0);
        tick();
        check("t6.count_after", 64'(count_o), 64'd0);
        check("t6.we1_after", 64'(we1_o), 64'd0);

        // Asynchronous reset between clock edges
        drive(1'b1, 5'd30, 32'h30, 1'b1, 5'd31, 32'h31);
        tick();
        drive(1'b1, 5'd1, 32'h32, 1'b1, 5'd2, 32'h33);
        tick();
        idle();
        check("t7.we1_pre", 64'(we1_o), 64'd1);
        check("t7.count_pre", 64'(count_o), 64'd2);
        #2;
        rst = 1'b1;
        #1;
        check("t7.count", 64'(count_o), 64'd0);
        check("t7.we1", 64'(we1_o), 64'd0);
        check("t7.we2", 64'(we2_o), 64'd0);
        check("t7.waddr1", 64'(waddr1_o), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        check("t7.count_post", 64'(count_o), 64'd0);
        check("t7.we1_post", 64'(we1_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
